// File: rtl/lint_l2_pkg.sv
// lint_l2_pkg: shared types and constants for the lint-to-L2 bank router
// Provides the FSM state enum, the issue/response register structs and the
// default error read pattern. Struct fields are sized for the largest supported
// geometry; the router uses only the low bits it needs.
package lint_l2_pkg;
    typedef enum logic {INIT, RUN} state_e;
    localparam int MAX_BANK_W = 8;
    localparam int MAX_ROW_W  = 24;
    localparam logic [31:0] DEF_ERR_RDATA = 32'hBADACCE5;
    typedef struct packed {
        logic                  valid;
        logic [MAX_BANK_W-1:0] bank;
        logic [MAX_ROW_W-1:0]  row;
        logic                  wen;
        logic [31:0]           wdata;
        logic [3:0]            be;
        logic                  oor;
    } iss_t;
    typedef struct packed {
        logic                  valid;
        logic [MAX_BANK_W-1:0] bank;
        logic                  wen;
        logic                  oor;
    } rsp_t;
endpackage

// File: rtl/lint_l2_bank_router_if.sv
// lint_l2_bank_router_if: single-word lint/TCDM request-response bus
// Ports (master view): req/add/wen/wdata/be out, gnt in;
// r_valid/r_rdata/r_opc in. wen=1 is a read, r_opc=1 flags an error response.
interface lint_l2_bank_router_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] add;
    logic              wen;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              r_valid;
    logic [31:0]       r_rdata;
    logic              r_opc;
    modport master (output req, add, wen, wdata, be, input gnt, r_valid, r_rdata, r_opc);
    modport slave  (input req, add, wen, wdata, be, output gnt, r_valid, r_rdata, r_opc);
endinterface

// File: rtl/lint_l2_addr_dec.sv
// lint_l2_addr_dec: word-interleaved bank/row decode with range check
// Ports: add_i byte address in; bank_o bank index, row_o row within bank,
// oor_o set when the word index lies beyond NB_BANKS*BANK_SIZE.
module lint_l2_addr_dec
    import lint_l2_pkg::*;
#(
    parameter int NB_BANKS  = 4,
    parameter int BANK_SIZE = 32768,
    parameter int ADDR_W    = 32,
    localparam int BW = $clog2(NB_BANKS),
    localparam int RW = $clog2(BANK_SIZE)
) (
    input  logic [ADDR_W-1:0] add_i,
    output logic [BW-1:0]     bank_o,
    output logic [RW-1:0]     row_o,
    output logic              oor_o
);
    logic [ADDR_W-3:0] w;
    logic              unused_lsb;
    assign w          = add_i[ADDR_W-1:2];
    assign unused_lsb = ^add_i[1:0];
    assign bank_o     = w[BW-1:0];
    assign row_o      = RW'(w >> BW);
    // Any word-index bit above bank+row means the address is past the last bank row.
    assign oor_o      = (w >> (BW + RW)) != '0;
endmodule

// File: rtl/lint_l2_bank_router.sv
// lint_l2_bank_router: lint slave driving word-interleaved multi-bank L2 SRAM
// Ports: clk_i/rst_i clock and async active-high reset; lint slave bus;
// bank_csn_o per-bank active-low select; bank_wen_o/addr/wdata/be shared bank
// command; bank_rdata_i per-bank read data one cycle after select;
// init_done_o high once the zero sweep has finished and requests are granted.
module lint_l2_bank_router
    import lint_l2_pkg::*;
#(
    parameter int          NB_BANKS      = 4,
    parameter int          BANK_SIZE     = 32768,
    parameter int          ADDR_W        = 32,
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter logic [31:0] ERR_RDATA     = DEF_ERR_RDATA,
    localparam int BW = $clog2(NB_BANKS),
    localparam int RW = $clog2(BANK_SIZE)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    lint_l2_bank_router_if.slave     lint,
    output logic [NB_BANKS-1:0]      bank_csn_o,
    output logic                     bank_wen_o,
    output logic [RW-1:0]            bank_addr_o,
    output logic [31:0]              bank_wdata_o,
    output logic [3:0]               bank_be_o,
    input  logic [NB_BANKS*32-1:0]   bank_rdata_i,
    output logic                     init_done_o
);
    state_e        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          init_done_q, init_done_d;
    iss_t          iss_q, iss_d;
    rsp_t          rsp_q, rsp_d;
    logic [BW-1:0] dec_bank;
    logic [RW-1:0] dec_row;
    logic          dec_oor;
    logic          sweep;
    logic [31:0]   rd_sel;
    logic          unused_hi;

    lint_l2_addr_dec #(.NB_BANKS(NB_BANKS), .BANK_SIZE(BANK_SIZE), .ADDR_W(ADDR_W)) u_dec (
        .add_i  (lint.add),
        .bank_o (dec_bank),
        .row_o  (dec_row),
        .oor_o  (dec_oor)
    );

    // The sweep starts one cycle after reset release so every select stays high while in reset.
    assign sweep     = state_q == INIT && armed_q;
    assign lint.gnt  = lint.req && state_q == RUN;
    assign unused_hi = ^{iss_q.bank[MAX_BANK_W-1:BW], iss_q.row[MAX_ROW_W-1:RW], rsp_q.bank[MAX_BANK_W-1:BW]};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        armed_d       = 1'b1;
        iss_d         = '0;
        iss_d.valid   = lint.gnt;
        iss_d.bank    = MAX_BANK_W'(dec_bank);
        iss_d.row     = MAX_ROW_W'(dec_row);
        iss_d.wen     = lint.wen;
        iss_d.wdata   = lint.wdata;
        iss_d.be      = lint.be;
        iss_d.oor     = dec_oor;
        rsp_d.valid   = iss_q.valid;
        rsp_d.bank    = iss_q.bank;
        rsp_d.wen     = iss_q.wen;
        rsp_d.oor     = iss_q.oor;
        if (sweep) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == RW'(BANK_SIZE - 1)) state_d = RUN;
        end
        init_done_d   = state_d == RUN;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= INIT_ON_RESET ? INIT : RUN;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            init_done_q <= 1'b0;
            iss_q       <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            init_done_q <= init_done_d;
            iss_q       <= iss_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bank_csn_o   = sweep ? '0 : (iss_q.valid && !iss_q.oor) ? ~(NB_BANKS'(1) << iss_q.bank[BW-1:0]) : '1;
    assign bank_wen_o   = sweep ? 1'b0 : iss_q.wen;
    assign bank_addr_o  = sweep ? cnt_q : iss_q.row[RW-1:0];
    assign bank_wdata_o = sweep ? 32'h0 : iss_q.wdata;
    assign bank_be_o    = sweep ? 4'hF : iss_q.be;
    assign init_done_o  = init_done_q;

    // Bank data is live in the response cycle, so the mux uses the bank index carried in rsp_q.
    assign rd_sel       = 32'(bank_rdata_i >> {rsp_q.bank[BW-1:0], 5'd0});
    assign lint.r_valid = rsp_q.valid;
    assign lint.r_opc   = rsp_q.valid && rsp_q.oor;
    assign lint.r_rdata = (!rsp_q.valid || !rsp_q.wen) ? 32'h0 : rsp_q.oor ? ERR_RDATA : rd_sel;
endmodule

// File: tb/tb_lint_l2_bank_router.sv
// tb_lint_l2_bank_router: directed self-checking bench for lint_l2_bank_router
module tb_lint_l2_bank_router;
    localparam int NB = 4;
    localparam int BS = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   csn;
    logic         bwen;
    logic [3:0]   baddr;
    logic [31:0]  bwdata;
    logic [3:0]   bbe;
    logic [127:0] brdata;
    logic         done;
    logic [31:0]  mem [NB][BS];
    logic [31:0]  rd [NB];
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    lint_l2_bank_router_if #(.ADDR_W(32)) lb ();

    lint_l2_bank_router #(
        .NB_BANKS(NB), .BANK_SIZE(BS), .ADDR_W(32), .INIT_ON_RESET(1'b1), .ERR_RDATA(32'hBADACCE5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lint         (lb),
        .bank_csn_o   (csn),
        .bank_wen_o   (bwen),
        .bank_addr_o  (baddr),
        .bank_wdata_o (bwdata),
        .bank_be_o    (bbe),
        .bank_rdata_i (brdata),
        .init_done_o  (done)
    );

    // SRAM macros: byte-masked write, registered read, one cycle after select.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (rst) rd[b] <= '0;
            else if (!csn[b]) begin
                if (!bwen) begin
                    for (int k = 0; k < 4; k++)
                        if (bbe[k]) mem[b][baddr][8*k +: 8] <= bwdata[8*k +: 8];
                end else rd[b] <= mem[b][baddr];
            end
        end
    end
    assign brdata = {rd[3], rd[2], rd[1], rd[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        lb.req = 1'b0; lb.add = '0; lb.wen = 1'b1; lb.wdata = '0; lb.be = '0;
    endtask

    task automatic xfer(input string tg, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, input logic [3:0] ecsn, input logic [3:0] erow,
                        input logic [31:0] erd, input logic eopc);
        lb.req = 1'b1; lb.add = a; lb.wen = w; lb.wdata = d; lb.be = b;
        #1 check({tg, " gnt"}, 32'(lb.gnt), 32'd1);
        @(negedge clk);
        idle();
        check({tg, " csn"}, 32'(csn), 32'(ecsn));
        if (ecsn != 4'hF) check({tg, " row"}, 32'(baddr), 32'(erow));
        check({tg, " early rvalid"}, 32'(lb.r_valid), 32'd0);
        @(negedge clk);
        check({tg, " rvalid"}, 32'(lb.r_valid), 32'd1);
        check({tg, " rdata"}, lb.r_rdata, erd);
        check({tg, " opc"}, 32'(lb.r_opc), 32'(eopc));
        @(negedge clk);
        check({tg, " rvalid drop"}, 32'(lb.r_valid), 32'd0);
        check({tg, " idle rdata"}, lb.r_rdata, 32'd0);
        check({tg, " idle opc"}, 32'(lb.r_opc), 32'd0);
    endtask

    initial begin
        logic [31:0] ba [6];
        logic        bw [6];
        logic [31:0] bd [6];
        logic [3:0]  ecs [6];
        int          low;
        int          gcnt;
        int          rvc;
        bit          found;
        ba  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h14, 32'h14};
        bw  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bd  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h55, 32'h0};
        ecs = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1101, 4'b1101};
        idle();
        lb.req = 1'b1;
        repeat (2) @(negedge clk);
        check("rst csn", 32'(csn), 32'hF);
        check("rst gnt", 32'(lb.gnt), 32'd0);
        check("rst rvalid", 32'(lb.r_valid), 32'd0);
        check("rst rdata", lb.r_rdata, 32'd0);
        check("rst opc", 32'(lb.r_opc), 32'd0);
        check("rst done", 32'(done), 32'd0);
        rst = 1'b0;
        low = 0; gcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            if (lb.gnt) gcnt++;
            if (csn == 4'h0) begin
                check("init row", 32'(baddr), 32'(low));
                check("init wen", 32'(bwen), 32'd0);
                low++;
            end
        end
        idle();
        check("init done", 32'(done), 32'd1);
        check("init rows", 32'(low), 32'd16);
        check("init gnt", 32'(gcnt), 32'd0);

        xfer("rd0", 32'h0, 1'b1, 32'h0, 4'hF, 4'b1110, 4'd0, 32'h0, 1'b0);
        xfer("wr8", 32'h8, 1'b0, 32'h12345678, 4'hF, 4'b1011, 4'd0, 32'h0, 1'b0);
        xfer("rd8", 32'h8, 1'b1, 32'h0, 4'hF, 4'b1011, 4'd0, 32'h12345678, 1'b0);
        xfer("wr8 be0", 32'h8, 1'b0, 32'hFFFFFFFF, 4'h0, 4'b1011, 4'd0, 32'h0, 1'b0);
        xfer("rd8 be0", 32'h8, 1'b1, 32'h0, 4'hF, 4'b1011, 4'd0, 32'h12345678, 1'b0);
        xfer("wr20 be5", 32'h20, 1'b0, 32'hAABBCCDD, 4'b0101, 4'b1110, 4'd2, 32'h0, 1'b0);
        xfer("rd20 be5", 32'h20, 1'b1, 32'h0, 4'hF, 4'b1110, 4'd2, 32'h00BB00DD, 1'b0);
        xfer("rd last", 32'hFC, 1'b1, 32'h0, 4'hF, 4'b0111, 4'd15, 32'h0, 1'b0);
        xfer("rd oor", 32'h100, 1'b1, 32'h0, 4'hF, 4'hF, 4'd0, 32'hBADACCE5, 1'b1);
        xfer("wr oor", 32'h100, 1'b0, 32'hDEADBEEF, 4'hF, 4'hF, 4'd0, 32'h0, 1'b1);

        for (int i = 0; i < 9; i++) begin
            check("burst csn", 32'(csn), (i >= 1 && i <= 6) ? 32'(ecs[i-1]) : 32'hF);
            check("burst rvalid", 32'(lb.r_valid), (i >= 2 && i <= 7) ? 32'd1 : 32'd0);
            check("burst rdata", lb.r_rdata, (i == 7) ? 32'h55 : 32'h0);
            if (i < 6) begin
                lb.req = 1'b1; lb.add = ba[i]; lb.wen = bw[i]; lb.wdata = bd[i]; lb.be = 4'hF;
            end else idle();
            #1 if (i < 6) check("burst gnt", 32'(lb.gnt), 32'd1);
            @(negedge clk);
        end
        xfer("rdC", 32'hC, 1'b1, 32'h0, 4'hF, 4'b0111, 4'd0, 32'hA3, 1'b0);

        lb.req = 1'b1; lb.add = 32'h4; lb.wen = 1'b1; lb.be = 4'hF;
        #1 check("rst gnt pre", 32'(lb.gnt), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("midrst csn", 32'(csn), 32'hF);
        check("midrst rvalid", 32'(lb.r_valid), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        idle();
        @(negedge clk);
        check("midrst rvalid2", 32'(lb.r_valid), 32'd0);
        rst = 1'b0;
        rvc = 0; found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lb.r_valid) rvc++;
            if (csn == 4'h0) begin
                check("restart row", 32'(baddr), 32'd0);
                found = 1'b1;
                break;
            end
        end
        check("restart found", 32'(found), 32'd1);
        check("restart rvalid", 32'(rvc), 32'd0);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("restart done", 32'(done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lint_l2_bank_router.md
Name: lint_l2_bank_router

Overview:
- Slave-side stage between the JTAG lint master and the multi-bank L2 SRAM macros.
- Accepts single-word TCDM/lint requests, decodes word-interleaved bank and row, and drives one SRAM bank per cycle.
- Returns read data/ack with fixed latency and handles out-of-range accesses.
- Optional zero-initialisation sweep of all banks after reset.

Parameters:
- NB_BANKS, 4, number of SRAM banks (power of 2, >=2)
- BANK_SIZE, 32768, words per bank (power of 2)
- ADDR_W, 32, lint address width
- INIT_ON_RESET, 1, 1 = zero all banks after reset before granting
- ERR_RDATA, 32'hBADACCE5, read data returned for out-of-range reads

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- lint_req_i  in  1  request valid
- lint_gnt_o  out  1  request accepted this cycle
- lint_add_i  in  ADDR_W  byte address (bits [1:0] ignored)
- lint_wen_i  in  1  0 = write, 1 = read
- lint_wdata_i  in  32  write data
- lint_be_i  in  4  byte enables
- lint_r_valid_o  out  1  response valid
- lint_r_rdata_o  out  32  read data
- lint_r_opc_o  out  1  1 = error response
- bank_csn_o  out  NB_BANKS  per-bank chip select, active low
- bank_wen_o  out  1  shared, 0 = write
- bank_addr_o  out  log2(BANK_SIZE)  shared row address
- bank_wdata_o  out  32  shared write data
- bank_be_o  out  4  shared byte enables
- bank_rdata_i  in  NB_BANKS*32  per-bank read data, valid 1 cycle after csn low
- init_done_o  out  1  sweep complete / router live

Behaviour:
- Reset: all csn high, lint_gnt_o=0, r_valid=0, r_rdata=0, r_opc=0, init_done_o=0, FSM=INIT if INIT_ON_RESET, else RUN with init_done_o=1 one cycle after reset release.
- Reset assertion mid-operation: in-flight request and response are discarded, no SRAM access completes after reset, and the sweep restarts.
- Address decode (word index W = add[ADDR_W-1:2]):
  - bank = W[log2(NB_BANKS)-1:0]
  - row = W >> log2(NB_BANKS), truncated to log2(BANK_SIZE)
  - in-range iff W < NB_BANKS*BANK_SIZE
- FSM INIT:
  - Row counter 0..BANK_SIZE-1; each cycle all csn low, wen=0, be=4'hF, wdata=0, addr=counter.
  - After row BANK_SIZE-1 is written, go to RUN; init_done_o=1 from the next cycle.
  - gnt=0 throughout INIT.
- FSM RUN:
  - Handshake: lint_gnt_o = lint_req_i (combinational) while RUN; every granted request is registered into a 1-entry issue register.
  - Cycle N: req&gnt.
  - Cycle N+1: selected bank csn low, with addr/wen/wdata/be from the issue register. Out-of-range: no csn asserted.
  - Cycle N+2: lint_r_valid_o=1 for exactly one cycle, for reads and writes alike.
    - In-range read: r_rdata = rdata of the bank captured at N+1.
    - Write: r_rdata=0.
    - Out-of-range read: r_rdata=ERR_RDATA, r_opc=1.
    - Out-of-range write: dropped, r_opc=1.
  - Back-to-back requests: full throughput, one per cycle; responses in order.
  - Read-after-write to the same word on consecutive cycles returns the new data (the SRAM serialises them).
- r_opc_o=0 and r_rdata_o=0 whenever r_valid_o=0.
- be=0 write: bank is still selected, memory is unchanged, response is normal.

Decomposition:
- Package lint_l2_pkg: fsm state enum {INIT, RUN}, issue-register struct {valid, bank, row, wen, wdata, be, oor}, default ERR_RDATA constant.
- Sub-module lint_l2_addr_dec: combinational bank/row/out-of-range decode, parameterised by NB_BANKS and BANK_SIZE.
- Top module holds the FSM, init counter, issue register and response register.

Test Plan:
- Reset release, INIT_ON_RESET=1, BANK_SIZE=16 -> exactly 16 cycles of all csn low, wen=0, addr 0..15; gnt=0; init_done_o rises; a subsequent read of 0x0 returns 0.
- Write 0x1234_5678 to 0x0000_0008, be=4'hF, then read 0x8 -> bank 2 selected, row 0; read r_valid 2 cycles after its gnt; rdata=0x12345678.
- Four back-to-back writes to 0x0, 0x4, 0x8, 0xC -> banks 0, 1, 2, 3 each selected once in consecutive cycles; four r_valid pulses in order.
- Read at address NB_BANKS*BANK_SIZE*4 -> no csn asserted; r_valid with r_opc=1, rdata=0xBADACCE5.
- Write 0xAABBCCDD with be=4'b0101, then read -> data = old bytes merged, e.g. 0x00BB00DD from zeroed memory.
- Assert rst_i the cycle after a grant -> no r_valid, all csn high, INIT restarts at row 0.
